// File: rtl/aluop_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aluop_defs (package)
// Brief    : Opcode and ALU-op encodings shared by the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package aluop_defs;

    // Instruction opcodes (5-bit field)
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // ALU operation encodings
    localparam logic [4:0] ALU_ADD       = 5'b00000;
    localparam logic [4:0] ALU_SUB       = 5'b00001;
    localparam logic [4:0] ALU_MAX_LEGAL = 5'b00111;

endpackage

`default_nettype wire

// File: rtl/aluop_decode_comb.sv
`default_nettype none
// ============================================================================
// Module   : aluop_decode_comb
// Brief    : Pure combinational opcode table: instruction -> ALU op,
//            immediate-select and illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module aluop_decode_comb
    import aluop_defs::*;
#(
    parameter int INSN_WIDTH   = 32,
    parameter int OPCODE_LSB   = 27,
    parameter int OPCODE_WIDTH = 5,
    parameter int ALUOP_WIDTH  = 5
) (
    input  logic [INSN_WIDTH-1:0]  insn,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   use_imm,
    output logic                   illegal
);

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ALUOP_WIDTH-1:0]  rtype_op;
    // Only the opcode and R-type ALU field are decoded; the rest is folded here
    logic                    unused_insn_bits;

    assign opcode           = insn[OPCODE_LSB+OPCODE_WIDTH-1 -: OPCODE_WIDTH];
    assign rtype_op         = insn[ALUOP_WIDTH+1:2];
    assign unused_insn_bits = ^insn;

    // Table lookup; anything not listed is flagged illegal
    always_comb begin
        alu_op  = ALUOP_WIDTH'(ALU_ADD);
        use_imm = 1'b0;
        illegal = 1'b1;
        case (opcode)
            OPCODE_WIDTH'(OP_RTYPE): begin
                alu_op  = rtype_op;
                illegal = (rtype_op > ALUOP_WIDTH'(ALU_MAX_LEGAL));
            end
            OPCODE_WIDTH'(OP_ADDI),
            OPCODE_WIDTH'(OP_SW),
            OPCODE_WIDTH'(OP_LW): begin
                use_imm = 1'b1;
                illegal = 1'b0;
            end
            OPCODE_WIDTH'(OP_BNE),
            OPCODE_WIDTH'(OP_BLT): begin
                alu_op  = ALUOP_WIDTH'(ALU_SUB);
                illegal = 1'b0;
            end
            OPCODE_WIDTH'(OP_J),
            OPCODE_WIDTH'(OP_JAL),
            OPCODE_WIDTH'(OP_JR),
            OPCODE_WIDTH'(OP_SETX),
            OPCODE_WIDTH'(OP_BEX): begin
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/aluop_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : aluop_decode_stage
// Brief    : Valid/ready decode stage with a DEPTH-entry output queue and a
//            saturating count of delivered instructions.
// Revision : 1.0 - initial release
// ============================================================================
module aluop_decode_stage
    import aluop_defs::*;
#(
    parameter int INSN_WIDTH   = 32,
    parameter int OPCODE_LSB   = 27,
    parameter int OPCODE_WIDTH = 5,
    parameter int ALUOP_WIDTH  = 5,
    parameter int DEPTH        = 2,   // power of two, >= 1
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [INSN_WIDTH-1:0]  in_insn,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSN_WIDTH-1:0]  out_insn,
    output logic [ALUOP_WIDTH-1:0] out_alu_op,
    output logic                   out_use_imm,
    output logic                   out_illegal,
    output logic [COUNT_WIDTH-1:0] decode_count
);

    // A 1-entry queue still needs a 1-bit pointer; it simply never moves
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [INSN_WIDTH-1:0]  mem_insn    [DEPTH];
    logic [ALUOP_WIDTH-1:0] mem_alu_op  [DEPTH];
    logic                   mem_use_imm [DEPTH];
    logic                   mem_illegal [DEPTH];

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       rd_next;
    logic [OCC_W-1:0]       occupancy;
    logic [OCC_W-1:0]       remaining;

    logic [ALUOP_WIDTH-1:0] dec_alu_op;
    logic                   dec_use_imm;
    logic                   dec_illegal;
    logic                   full;
    logic                   push;
    logic                   pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    aluop_decode_comb #(
        .INSN_WIDTH   (INSN_WIDTH),
        .OPCODE_LSB   (OPCODE_LSB),
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .ALUOP_WIDTH  (ALUOP_WIDTH)
    ) u_decode (
        .insn    (in_insn),
        .alu_op  (dec_alu_op),
        .use_imm (dec_use_imm),
        .illegal (dec_illegal)
    );

    assign full      = (occupancy == OCC_W'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (occupancy != '0);
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;
    assign rd_next   = pop ? ptr_inc(rd_ptr) : rd_ptr;
    // Entries left in storage after this edge's pop, not counting the push
    assign remaining = occupancy - OCC_W'(pop);

    // Queue storage: decoded entry lands at the write pointer on a push
    always_ff @(posedge clock) begin
        if (push) begin
            mem_insn[wr_ptr]    <= in_insn;
            mem_alu_op[wr_ptr]  <= dec_alu_op;
            mem_use_imm[wr_ptr] <= dec_use_imm;
            mem_illegal[wr_ptr] <= dec_illegal;
        end
    end

    // Pointers, occupancy and the registered head-of-queue outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            out_insn    <= '0;
            out_alu_op  <= '0;
            out_use_imm <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr    <= rd_next;
            occupancy <= remaining + OCC_W'(push);
            // Head comes from storage if anything older survives, otherwise
            // from the entry being pushed; with neither, hold the last value
            if (remaining != '0) begin
                out_insn    <= mem_insn[rd_next];
                out_alu_op  <= mem_alu_op[rd_next];
                out_use_imm <= mem_use_imm[rd_next];
                out_illegal <= mem_illegal[rd_next];
            end else if (push) begin
                out_insn    <= in_insn;
                out_alu_op  <= dec_alu_op;
                out_use_imm <= dec_use_imm;
                out_illegal <= dec_illegal;
            end
        end
    end

    // Saturating count of output handshakes
    always_ff @(posedge clock) begin
        if (reset) begin
            decode_count <= '0;
        end else if (pop && (decode_count != '1)) begin
            decode_count <= decode_count + 1'b1;
        end
    end

endmodule

`default_nettype wire
